iter_shift_unit: RTL

//  Parametrised multi-mode shift unit for the ALU: SRL/SLL/SRA/ROR/ROL of a selected operand by a runtime amount.

---
 rtl/shift_pkg.sv | 39 +++
 rtl/shift_step.sv | 60 ++++++
 rtl/iter_shift_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// Module  : shift_pkg
// Brief   : Shared encodings and width helpers for the iterative shift unit.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef enum logic [2:0] {
        FN_SRL = 3'b000,
        FN_SLL = 3'b001,
        FN_SRA = 3'b010,
        FN_ROR = 3'b011,
        FN_ROL = 3'b100
    } alu_func_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [2:0] c_fn_max = 3'b100;

    function automatic int shamt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

    function automatic int step_cnt_width(input int step);
        return (step < 1) ? 1 : $clog2(step + 1);
    endfunction

    function automatic logic func_is_legal(input logic [2:0] f);
        return (f <= c_fn_max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module  : shift_step
// Brief   : Combinational single-iteration shifter, moves a word 0..STEP bits.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STEP       = 4,
    localparam int CNT_W     = step_cnt_width(STEP)
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0]      i_amt,
    input  alu_func_e             i_mode,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_carry
);

    // Amount 0 passes the word through with no carry.
    always_comb begin
        o_data  = i_data;
        o_carry = 1'b0;
        for (int i = 1; i <= STEP; i++) begin
            if (i_amt == CNT_W'(i)) begin
                case (i_mode)
                    FN_SRL: begin
                        o_data  = i_data >> i;
                        o_carry = i_data[i-1];
                    end
                    FN_SLL: begin
                        o_data  = i_data << i;
                        o_carry = i_data[DATA_WIDTH-i];
                    end
                    FN_SRA: begin
                        o_data  = $unsigned($signed(i_data) >>> i);
                        o_carry = i_data[i-1];
                    end
                    FN_ROR: begin
                        o_data  = (i_data >> i) | (i_data << (DATA_WIDTH - i));
                        o_carry = i_data[i-1];
                    end
                    FN_ROL: begin
                        o_data  = (i_data << i) | (i_data >> (DATA_WIDTH - i));
                        o_carry = i_data[DATA_WIDTH-i];
                    end
                    default: begin
                        o_data  = i_data;
                        o_carry = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/iter_shift_unit.sv
// ============================================================================
// Module  : iter_shift_unit
// Brief   : Iterative SRL/SLL/SRA/ROR/ROL unit with start/busy/done handshake.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int STEP         = 4,
    localparam int SHAMT_WIDTH = shamt_width(DATA_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  A,
    input  logic [DATA_WIDTH-1:0]  B,
    input  logic                   SRC_SEL,
    input  logic [2:0]             ALU_FUNC,
    input  logic [SHAMT_WIDTH-1:0] SHAMT,
    input  logic                   Shift_enable,
    output logic                   Busy,
    output logic [DATA_WIDTH-1:0]  Shift_OUT,
    output logic                   Carry_OUT,
    output logic                   Shift_Flag,
    output logic                   Shift_Err
);

    localparam int CNT_W = step_cnt_width(STEP);
    localparam logic [SHAMT_WIDTH-1:0] c_width = SHAMT_WIDTH'(DATA_WIDTH);
    localparam logic [SHAMT_WIDTH-1:0] c_step  = SHAMT_WIDTH'(STEP);

    state_e                  r_state;
    logic [DATA_WIDTH-1:0]   r_data;
    alu_func_e               r_func;
    logic [SHAMT_WIDTH-1:0]  r_rem;
    logic                    r_sat;
    logic                    r_illegal;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   r_out;
    logic                    r_carry;
    logic                    r_flag;
    logic                    r_err;

    logic [DATA_WIDTH-1:0]   w_operand;
    logic                    w_legal;
    logic                    w_is_rot;
    logic [SHAMT_WIDTH-1:0]  w_rem_init;
    logic [CNT_W-1:0]        w_k;
    logic [SHAMT_WIDTH-1:0]  w_rem_next;
    logic [DATA_WIDTH-1:0]   w_step_data;
    logic                    w_step_carry;

    assign w_operand = SRC_SEL ? B : A;
    assign w_legal   = func_is_legal(ALU_FUNC);
    assign w_is_rot  = (ALU_FUNC == FN_ROR) || (ALU_FUNC == FN_ROL);

    // Rotates wrap the amount; linear shifts saturate at the word width.
    always_comb begin
        w_rem_init = SHAMT;
        if (w_is_rot) begin
            w_rem_init = SHAMT % c_width;
        end else if (SHAMT > c_width) begin
            w_rem_init = c_width;
        end
    end

    assign w_k        = (r_rem > c_step) ? CNT_W'(STEP) : r_rem[CNT_W-1:0];
    assign w_rem_next = r_rem - SHAMT_WIDTH'(w_k);

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .STEP       (STEP)
    ) u_step (
        .i_data  (r_data),
        .i_amt   (w_k),
        .i_mode  (r_func),
        .o_data  (w_step_data),
        .o_carry (w_step_carry)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_func    <= FN_SRL;
            r_rem     <= '0;
            r_sat     <= 1'b0;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_out     <= '0;
            r_carry   <= 1'b0;
            r_flag    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_flag <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Shift_enable) begin
                        r_data    <= w_operand;
                        r_func    <= w_legal ? alu_func_e'(ALU_FUNC) : FN_SRL;
                        r_illegal <= ~w_legal;
                        r_rem     <= w_rem_init;
                        r_sat     <= ~w_is_rot && (SHAMT > c_width);
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (r_illegal) begin
                        r_out   <= '0;
                        r_carry <= 1'b0;
                        r_flag  <= 1'b1;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_data <= w_step_data;
                        r_rem  <= w_rem_next;
                        if (w_rem_next == '0) begin
                            r_out   <= w_step_data;
                            r_carry <= w_step_carry & ~r_sat;
                            r_flag  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy       = r_busy;
    assign Shift_OUT  = r_out;
    assign Carry_OUT  = r_carry;
    assign Shift_Flag = r_flag;
    assign Shift_Err  = r_err;

endmodule

`default_nettype wire
